fft_seq_ctrl: RTL and testbench

Frame sequencer for the 128-point in-place radix-2 FFT core. It accepts a start request and drives the `ce` input of the FFT RAM address generator for exactly one frame. From a shadow copy of the generator's cycle counter it produces the sample-load, RAM read/write enable, stage index, twiddle-ROM address and output-valid strobes. It sits between the system control/stream interfaces and the FFT RAM, address generator, butterfly and twiddle ROM.

---
 rtl/fft_seq_ctrl.sv | 112 +++++++++++
 tb/tb_fft_seq_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fft_seq_ctrl.sv
// Frame sequencer for the 128-point in-place radix-2 FFT: drives the address-generator enable
// and decodes RAM/twiddle/stream strobes from a shadow copy of the generator's cycle counter.
module fft_seq_ctrl #(
  parameter int unsigned N_PTS  = 128,
  parameter int unsigned BF_LAT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       in_valid,
  output logic       ce,
  output logic       busy,
  output logic       in_ready,
  output logic       ram_we,
  output logic       ram_re,
  output logic [2:0] stage,
  output logic       bfly_start,
  output logic [5:0] tw_addr,
  output logic       out_valid,
  output logic       done,
  output logic       load_err
);

  localparam int unsigned Stages = 7;
  localparam logic [10:0] LoadEnd = 11'(N_PTS);
  localparam logic [10:0] ReadBeg = 11'(N_PTS + 1);
  localparam logic [10:0] ReadEnd = 11'(N_PTS * (Stages + 1));
  localparam logic [10:0] UnlBeg  = 11'(N_PTS * (Stages + 1) + 1);
  localparam logic [10:0] UnlEnd  = 11'(N_PTS * (Stages + 2) + 1);
  localparam logic [10:0] WeLdBeg = 11'(2);
  localparam logic [10:0] WeLdEnd = 11'(N_PTS + 1);
  localparam logic [10:0] WeBeg   = 11'(N_PTS + 1 + BF_LAT);
  localparam logic [10:0] WeEnd   = 11'(N_PTS * (Stages + 1) + BF_LAT);

  typedef enum logic [2:0] {StIdle, StLoad, StCompute, StUnload, StDone} state_e;

  state_e      state_q;
  logic [10:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      ce       <= 1'b0;
      done     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      done  <= 1'b0;
      cnt_q <= ce ? cnt_q + 11'd1 : 11'd0;
      if (in_ready && !in_valid) load_err <= 1'b1;
      if (abort && state_q != StIdle) begin
        state_q <= StIdle;
        ce      <= 1'b0;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start && !abort) begin
              state_q  <= StLoad;
              ce       <= 1'b1;
              load_err <= 1'b0;
            end
          end
          StLoad:    if (cnt_q == LoadEnd) state_q <= StCompute;
          StCompute: if (cnt_q == ReadEnd) state_q <= StUnload;
          StUnload: begin
            if (cnt_q == UnlEnd) begin
              state_q <= StDone;
              ce      <= 1'b0;
              done    <= 1'b1;
            end
          end
          StDone:    state_q <= StIdle;
          default:   state_q <= StIdle;
        endcase
      end
    end
  end

  logic       rd_stage;
  logic [9:0] off;
  logic [2:0] rd_s;
  logic [5:0] bidx;
  logic [5:0] tw_mask;

  always_comb begin
    busy     = (state_q != StIdle);
    in_ready = (cnt_q >= 11'd1) && (cnt_q <= LoadEnd);
    rd_stage = (cnt_q >= ReadBeg) && (cnt_q <= ReadEnd);
    off      = 10'(cnt_q - ReadBeg);
    rd_s     = off[9:7];
    bidx     = off[6:1];
    // Butterfly b of stage s uses twiddle exponent (b mod 2^s) scaled to the 64-entry ROM.
    tw_mask  = ~(6'h3f << rd_s);
    ram_we   = ((cnt_q >= WeLdBeg) && (cnt_q <= WeLdEnd)) ||
               ((cnt_q >= WeBeg) && (cnt_q <= WeEnd));
    ram_re   = rd_stage || ((cnt_q >= UnlBeg) && (cnt_q < UnlEnd));
    out_valid = (cnt_q > UnlBeg) && (cnt_q <= UnlEnd);
    stage      = 3'd0;
    bfly_start = 1'b0;
    tw_addr    = 6'd0;
    if (rd_stage) begin
      stage      = rd_s;
      bfly_start = ~off[0];
      tw_addr    = (bidx & tw_mask) << (3'd6 - rd_s);
    end else if ((cnt_q >= UnlBeg) && (cnt_q <= UnlEnd)) begin
      stage = 3'd6;
    end
  end

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Directed bench for fft_seq_ctrl: full frames, load error, abort, restart and async reset.
module tb_fft_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, abort, in_valid;
  logic       ce, busy, in_ready, ram_we, ram_re, bfly_start, out_valid, done, load_err;
  logic [2:0] stage;
  logic [5:0] tw_addr;

  int n_checks = 0;
  int n_fail   = 0;

  fft_seq_ctrl #(.N_PTS(128), .BF_LAT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .in_valid   (in_valid),
    .ce         (ce),
    .busy       (busy),
    .in_ready   (in_ready),
    .ram_we     (ram_we),
    .ram_re     (ram_re),
    .stage      (stage),
    .bfly_start (bfly_start),
    .tw_addr    (tw_addr),
    .out_valid  (out_valid),
    .done       (done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycle c of a frame: start is high in cycle 0, so cnt = c-1 from cycle 2 on.
  task automatic run_frame(input int err_cnt, input int abort_cnt, input int restart_cnt,
                           input bit start_in_done);
    int n_rdy = 0, n_we = 0, n_re = 0, n_ov = 0, n_bf = 0, n_bf0 = 0, n_done = 0;
    int done_cyc = -1, first_ov = -1;
    logic [5:0] tw0_or = '0;
    int last = (abort_cnt >= 0) ? abort_cnt + 12 : 1158;
    for (int c = 0; c <= last; c++) begin
      start    = (c == 0) || (c == restart_cnt + 1) || (start_in_done && c == 1155);
      in_valid = !(err_cnt >= 0 && c == err_cnt + 1);
      abort    = (abort_cnt >= 0 && c == abort_cnt + 1);
      if (c == 0) begin
        check("idle_ce", ce, 0);
        check("idle_busy", busy, 0);
      end
      if (c == 1) begin
        check("ce_rise", ce, 1);
        check("busy_rise", busy, 1);
        check("err_clr_on_start", load_err, 0);
      end
      n_rdy += int'(in_ready);
      n_we  += int'(ram_we);
      n_re  += int'(ram_re);
      n_ov  += int'(out_valid);
      n_bf  += int'(bfly_start);
      if (out_valid && first_ov < 0) first_ov = c;
      if (done) begin
        n_done++;
        done_cyc = c;
      end
      if (c >= 130 && c <= 257 && bfly_start) begin
        n_bf0++;
        tw0_or |= tw_addr;
      end
      if (err_cnt >= 0 && c == err_cnt + 2) check("err_set", load_err, 1);
      if (abort_cnt >= 0 && c == abort_cnt + 2) begin
        check("abort_ce", ce, 0);
        check("abort_busy", busy, 0);
        check("abort_keeps_err", load_err, (err_cnt >= 0) ? 1 : 0);
      end
      if (abort_cnt < 0) begin
        if (c == 524) begin
          check("s3_stage", stage, 3);
          check("s3_bfly", bfly_start, 1);
          check("s3_b5_tw", tw_addr, 40);
        end
        if (c == 525) check("s3_b5_tw_hold", tw_addr, 40);
        if (c == 1024) begin
          check("s6_stage", stage, 6);
          check("s6_b63_tw", tw_addr, 63);
        end
        if (c == 1100) check("unload_stage", stage, 6);
        if (c == 1155) begin
          check("done_ce_low", ce, 0);
          check("err_through_done", load_err, (err_cnt >= 0) ? 1 : 0);
        end
        if (c == 1156) begin
          check("busy_after_done", busy, 0);
          check("done_pulse_width", done, 0);
        end
      end
      tick();
    end
    start = 1'b0; abort = 1'b0; in_valid = 1'b1;
    if (abort_cnt < 0) begin
      check("done_count", n_done, 1);
      check("done_cycle", done_cyc, 1155);
      check("in_ready_cnt", n_rdy, 128);
      check("ram_we_cnt", n_we, 1024);
      check("ram_re_cnt", n_re, 1024);
      check("out_valid_cnt", n_ov, 128);
      check("out_valid_first", first_ov, 1027);
      check("bfly_cnt", n_bf, 448);
      check("s0_bfly_cnt", n_bf0, 64);
      check("s0_tw_zero", tw0_or, 0);
    end else begin
      check("abort_no_done", n_done, 0);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outs", {ce, busy, in_ready, ram_we, ram_re, bfly_start, out_valid, done, load_err,
                       stage, tw_addr}, 0);
    rst = 1'b1;
    tick();
    // start and abort together in IDLE: abort wins
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle", busy, 0);
    tick();

    run_frame(-1, -1, 10, 1'b1);
    repeat (2) tick();
    run_frame(50, -1, -1, 1'b0);
    check("err_sticky_idle", load_err, 1);
    repeat (2) tick();
    run_frame(50, 600, -1, 1'b0);
    repeat (2) tick();
    run_frame(-1, -1, -1, 1'b0);
    repeat (2) tick();

    // async reset mid-frame at cnt=300
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (300) tick();
    check("pre_rst_active", {ram_we, ram_re, stage}, {1'b1, 1'b1, 3'd1});
    rst = 1'b0;
    #1;
    check("async_rst_outs", {ce, busy, in_ready, ram_we, ram_re, bfly_start, out_valid, done,
                             load_err, stage, tw_addr}, 0);
    tick();
    rst = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
